// File: rtl/prescaler_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prescaler_ctrl : programmable clock-enable tick generator with config     |
// |   handshake, start/stop, one-shot/periodic modes and a wrapping tick count.|
// |   Optional clk_out square wave when PRESCALER_CTRL_CLKOUT_EN is defined.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module prescaler_ctrl #(
  parameter int N  = 22,
  parameter int TW = 8
) (
  input  logic          clk_in,
  input  logic          rstn,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_div,
  input  logic          cfg_periodic,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          tick,
  output logic          done,
  output logic [TW-1:0] tick_cnt
`ifdef PRESCALER_CTRL_CLKOUT_EN
  ,
  output logic          clk_out
`endif
);

  localparam logic [N-1:0]  c_one_n  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] c_one_tw = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_period;
  logic          r_periodic;
  logic [N-1:0]  r_cnt;
  logic [N-1:0]  w_cnt_nxt;
  logic [N-1:0]  w_last;
  logic          w_cfg_xfer;
  logic          w_tick_nxt;
  logic [TW-1:0] w_tcnt_nxt;

  assign w_cfg_xfer = cfg_valid && (r_state != S_RUN);
  assign w_last     = r_period - c_one_n;
  assign cfg_ready  = (r_state != S_RUN);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_period   <= c_one_n;
      r_periodic <= 1'b0;
    end else if (w_cfg_xfer) begin
      r_period   <= (cfg_div == '0) ? c_one_n : cfg_div;
      r_periodic <= cfg_periodic;
    end
  end

  // Priority inside RUN: stop, then retrigger, then expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    w_tcnt_nxt  = tick_cnt;
    case (r_state)
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (start) begin
          w_cnt_nxt   = '0;
        end else if (r_cnt == w_last) begin
          w_cnt_nxt   = '0;
          w_tick_nxt  = 1'b1;
          w_tcnt_nxt  = tick_cnt + c_one_tw;
          if (!r_periodic) begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + c_one_n;
        end
      end
      default: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_tcnt_nxt  = '0;
        end else if (w_cfg_xfer) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      tick     <= w_tick_nxt;
      busy     <= (w_state_nxt == S_RUN);
      done     <= (w_state_nxt == S_DONE);
      tick_cnt <= w_tcnt_nxt;
    end
  end

`ifdef PRESCALER_CTRL_CLKOUT_EN
  logic r_clk_out;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      r_clk_out <= 1'b0;
    end else if (w_tick_nxt) begin
      r_clk_out <= ~r_clk_out;
    end
  end

  assign clk_out = r_clk_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prescaler_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prescaler_ctrl : scoreboard bench for prescaler_ctrl; expected ticks   |
// |   come from an absolute-time model of the period rules.                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_prescaler_ctrl;

  localparam int N  = 22;
  localparam int TW = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk_in = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [N-1:0]  cfg_div = '0;
  logic          cfg_periodic = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy;
  logic          tick;
  logic          done;
  logic [TW-1:0] tick_cnt;
`ifdef PRESCALER_CTRL_CLKOUT_EN
  logic          clk_out;
`endif

  prescaler_ctrl #(.N(N), .TW(TW)) u_dut (
    .clk_in       (clk_in),
    .rstn         (rstn),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .tick_cnt     (tick_cnt)
`ifdef PRESCALER_CTRL_CLKOUT_EN
    ,
    .clk_out      (clk_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int at_edge;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b0;

  // Reference model: absolute edge number of the next expiry instead of a counter.
  int   m_state;
  int   m_p;
  bit   m_per;
  int   m_next;
  int   m_tcnt;
  bit   m_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_p     = 1;
    m_per   = 1'b0;
    m_next  = 0;
    m_tcnt  = 0;
    m_clk   = 1'b0;
  endtask

  task automatic model_edge();
    bit xfer;
    xfer = cfg_valid && (m_state != M_RUN);
    if (xfer) begin
      m_p   = (cfg_div == '0) ? 1 : int'(cfg_div);
      m_per = cfg_periodic;
    end
    if (m_state != M_RUN) begin
      if (stop) m_state = M_IDLE;
      else if (start) begin
        m_state = M_RUN;
        m_next  = edge_n + m_p;
        m_tcnt  = 0;
      end else if (xfer) m_state = M_IDLE;
    end else begin
      if (stop) m_state = M_IDLE;
      else if (start) m_next = edge_n + m_p;
      else if (edge_n == m_next) begin
        m_tcnt = (m_tcnt + 1) % (1 << TW);
        exp_q.push_back(exp_t'{at_edge: edge_n, cnt: m_tcnt});
        m_clk  = ~m_clk;
        m_next = m_next + m_p;
        if (!m_per) m_state = M_DONE;
      end
    end
  endtask

  task automatic drv(input bit v, input int d, input bit per, input bit st, input bit sp);
    cfg_valid    = v;
    cfg_div      = N'(d);
    cfg_periodic = per;
    start        = st;
    stop         = sp;
    @(posedge clk_in);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tick_cnt"}, int'(tick_cnt), 0);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
`ifdef PRESCALER_CTRL_CLKOUT_EN
    chk({tag, "_clk_out"}, int'(clk_out), 0);
`endif
  endtask

  always @(negedge clk_in) begin
    if (mon_en) begin
      bit   exp_tick;
      exp_t e;
      exp_tick = (exp_q.size() > 0) && (exp_q[0].at_edge == edge_n);
      chk("tick", int'(tick), int'(exp_tick));
      if (tick && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick_edge", edge_n, e.at_edge);
        chk("tick_cnt_at_tick", int'(tick_cnt), e.cnt);
      end else if (!tick && exp_tick) begin
        void'(exp_q.pop_front());
      end
      chk("busy", int'(busy), int'(m_state == M_RUN));
      chk("done", int'(done), int'(m_state == M_DONE));
      chk("cfg_ready", int'(cfg_ready), int'(m_state != M_RUN));
      chk("tick_cnt", int'(tick_cnt), m_tcnt);
`ifdef PRESCALER_CTRL_CLKOUT_EN
      chk("clk_out", int'(clk_out), int'(m_clk));
`endif
    end
  end

  initial begin
    model_reset();
    #23;
    chk_reset_vals("por");
    @(posedge clk_in);
    edge_n++;
    #1 rstn = 1'b1;
    mon_en = 1'b1;

    // Periodic P=5 with a config offer during RUN that must be ignored.
    drv(1'b1, 5, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(6);
    drv(1'b1, 9, 1'b0, 1'b0, 1'b0);
    idle(10);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // One-shot P=3, then restart from DONE.
    drv(1'b1, 3, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(6);
    drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // Periodic P=4 (config+start together), stop on the second expiry edge.
    drv(1'b1, 4, 1'b1, 1'b1, 1'b0);
    idle(7);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // cfg_div = 0 behaves as P=1.
    drv(1'b1, 0, 1'b1, 1'b1, 1'b0);
    idle(5);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Retrigger on the expiry edge of P=2.
    drv(1'b1, 2, 1'b1, 1'b1, 1'b0);
    idle(1);
    drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(6);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // tick_cnt wrap with P=1.
    drv(1'b1, 1, 1'b1, 1'b1, 1'b0);
    idle(260);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      drv($urandom_range(99) < 20, int'($urandom_range(6)), 1'($urandom_range(1)),
          $urandom_range(99) < 8, $urandom_range(99) < 4);
    end

    // Asynchronous reset in the middle of a periodic P=3 run.
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1);
    drv(1'b1, 3, 1'b1, 1'b1, 1'b0);
    idle(8);
    #1 rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk_reset_vals("async");
    exp_q.delete();
    model_reset();
    repeat (2) begin
      @(posedge clk_in);
      edge_n++;
    end
    #1 rstn = 1'b1;
    mon_en = 1'b1;

    // Reset period is 1, one-shot.
    drv(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(4);

    idle(2);
    mon_en = 1'b0;
    chk("leftover_ticks", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
